// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath types: coefficient word, parallel row, row-bank state.
package jpeg_pkg;

  localparam int unsigned COEF_W  = 48;
  localparam int unsigned ROW_LEN = 8;
  localparam int unsigned IDX_W   = 3;

  typedef logic [COEF_W-1:0] coef_t;

  // Element 0 is word a, element ROW_LEN-1 is word h.
  typedef coef_t [ROW_LEN-1:0] row_t;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

endpackage

// File: rtl/row_bank.sv
// One parallel row register with load enable, full flag and an indexed word read port.
module row_bank
  import jpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  row_t             din,
  input  logic [IDX_W-1:0] idx,
  output coef_t            dout,
  output logic             full
);

  bank_state_e state, state_nxt;
  row_t        data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BANK_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BANK_EMPTY: if (load)  state_nxt = BANK_FULL;
      BANK_FULL:  if (clear) state_nxt = BANK_EMPTY;
      default:    state_nxt = BANK_EMPTY;
    endcase
  end

  // Capture only into an empty bank so a row being read never changes underneath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              data <= '0;
    else if (load && state == BANK_EMPTY) data <= din;
  end

  assign dout = data[idx];
  assign full = (state == BANK_FULL);

endmodule

// File: rtl/row_ser.sv
// Row serializer: parallel row a..h in, one coefficient per cycle out.
// Define ROW_SER_PINGPONG_EN for two banks (accept next row while draining).
module row_ser #(
  parameter int unsigned COEF_W  = 48,
  parameter int unsigned ROW_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  logic [COEF_W-1:0] c,
  input  logic [COEF_W-1:0] d,
  input  logic [COEF_W-1:0] e,
  input  logic [COEF_W-1:0] f,
  input  logic [COEF_W-1:0] g,
  input  logic [COEF_W-1:0] h,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [COEF_W-1:0] y,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  import jpeg_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(ROW_LEN - 1);

  row_t       row_in;
  logic       accept;
  logic       xfer;
  logic       last_xfer;
  logic [2:0] idx_q;

  assign row_in    = {h, g, f, e, d, c, b, a};
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & (idx_q == LAST_IDX);

`ifdef ROW_SER_PINGPONG_EN
  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] full;
  logic [1:0] load;
  logic [1:0] clear;
  coef_t      word0;
  coef_t      word1;

  assign load  = {accept & wr_sel,    accept & ~wr_sel};
  assign clear = {last_xfer & rd_sel, last_xfer & ~rd_sel};

  row_bank u_bank0 (
    .clk(clk), .rst(rst), .load(load[0]), .clear(clear[0]),
    .din(row_in), .idx(idx_q), .dout(word0), .full(full[0])
  );

  row_bank u_bank1 (
    .clk(clk), .rst(rst), .load(load[1]), .clear(clear[1]),
    .din(row_in), .idx(idx_q), .dout(word1), .full(full[1])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (accept)    wr_sel <= ~wr_sel;
      if (last_xfer) rd_sel <= ~rd_sel;
    end
  end

  assign in_ready  = ~rst & ~(wr_sel ? full[1] : full[0]);
  assign out_valid = rd_sel ? full[1] : full[0];
  assign y         = rd_sel ? word1 : word0;
`else
  // Single bank: both selects are implicitly 0, so no select registers exist.
  logic  full;
  coef_t word0;

  row_bank u_bank0 (
    .clk(clk), .rst(rst), .load(accept), .clear(last_xfer),
    .din(row_in), .idx(idx_q), .dout(word0), .full(full)
  );

  assign in_ready  = ~rst & ~full;
  assign out_valid = full;
  assign y         = word0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       idx_q <= '0;
    else if (xfer) idx_q <= idx_q + 3'd1;
  end

  assign out_idx  = idx_q;
  assign out_last = out_valid & (idx_q == LAST_IDX);
  assign busy     = |full;

endmodule

// File: tb/tb_row_ser.sv
// Scoreboard bench for row_ser; expectations follow ROW_SER_PINGPONG_EN when defined.
module tb_row_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] a, b, c, d, e, f, g, h;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] y;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  typedef struct packed {
    logic [47:0] w;
    logic [2:0]  idx;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_y;
  logic [2:0]  prev_idx;

  row_ser #(.COEF_W(48), .ROW_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_row(input logic [47:0] base);
    a = base;        b = base + 48'd1; c = base + 48'd2; d = base + 48'd3;
    e = base + 48'd4; f = base + 48'd5; g = base + 48'd6; h = base + 48'd7;
  endtask

  // Returns just after the accepting edge (posedge + 1).
  task automatic offer(input logic [47:0] base);
    logic acc;
    int   n;
    set_row(base);
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("offer_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [2:0] k);
    int n;
    n = 0;
    while (!(out_valid && out_idx == k) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("idx_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable at the falling edge and take effect at the next rising edge.
  always @(negedge clk) begin
    exp_t ex;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_y", 64'(y), 64'(prev_y));
        chk("stall_idx", 64'(out_idx), 64'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          ex = sbq.pop_front();
          chk("sb_y", 64'(y), 64'(ex.w));
          chk("sb_idx", 64'(out_idx), 64'(ex.idx));
          chk("sb_last", 64'(out_last), 64'(ex.idx == 3'd7));
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{w: a, idx: 3'd0});
        sbq.push_back('{w: b, idx: 3'd1});
        sbq.push_back('{w: c, idx: 3'd2});
        sbq.push_back('{w: d, idx: 3'd3});
        sbq.push_back('{w: e, idx: 3'd4});
        sbq.push_back('{w: f, idx: 3'd5});
        sbq.push_back('{w: g, idx: 3'd6});
        sbq.push_back('{w: h, idx: 3'd7});
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_idx   = out_idx;
    end
  end

  initial begin
    int first, last, cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_row(48'd0);
    repeat (2) @(posedge clk);

    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Single row 1..8 with free-running sink.
    @(posedge clk);
    #1 out_ready = 1'b1;
    offer(48'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_idx", 64'(out_idx), 64'(k));
      chk("t1_y", 64'(y), 64'(k + 1));
      chk("t1_last", 64'(out_last), 64'(k == 7));
    end
    @(negedge clk);
    chk("t1_done", 64'(out_valid), 64'd0);
    wait_idle();

    // Backpressure at word 3.
    offer(48'h30);
    wait_idx(3'd3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_y", 64'(y), 64'h33);
      chk("bp_idx", 64'(out_idx), 64'd3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back rows with in_valid held.
    first = -1;
    last = -1;
    cnt = 0;
    fork
      begin
        offer(48'h10);
        offer(48'h20);
      end
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) begin
          if (first < 0) first = i;
          last = i;
          cnt++;
        end
      end
    join
    chk("b2b_count", 64'(cnt), 64'd16);
`ifdef ROW_SER_PINGPONG_EN
    chk("b2b_span", 64'(last - first + 1), 64'd16);
`else
    chk("b2b_span", 64'(last - first + 1), 64'd17);
`endif
    wait_idle();

    // Full block, plus ignored input while in_ready is low.
    out_ready = 1'b0;
    offer(48'h40);
`ifdef ROW_SER_PINGPONG_EN
    offer(48'h50);
`endif
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 48'($urandom); b = 48'($urandom); c = 48'($urandom); d = 48'($urandom);
      e = 48'($urandom); f = 48'($urandom); g = 48'($urandom); h = 48'($urandom);
      @(negedge clk);
      chk("fb_in_ready", 64'(in_ready), 64'd0);
      chk("fb_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fb_hold", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("fb_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    offer(48'h60);
    wait_idle();

    // Asynchronous reset in the middle of a row.
    offer(48'h70);
    wait_idx(3'd5);
    #2 rst = 1'b1;
    sbq.delete();
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_y", 64'(y), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_idx", 64'(out_idx), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    offer(48'h80);
    @(negedge clk);
    chk("mr_next_idx", 64'(out_idx), 64'd0);
    chk("mr_next_y", 64'(y), 64'h80);
    wait_idle();

    chk("sb_left", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
